// File: rtl/lif_neuron_layer.sv
// lif_neuron_layer: layer of leaky integrate-and-fire neurons updated serially, one neuron per cycle per time step.
// Define LIF_STDP_EN to enable on-chip STDP weight learning on fire; otherwise learn is ignored.
module lif_neuron_layer #(
    parameter int                N_INPUTS      = 8,
    parameter int                N_NEURONS     = 4,
    parameter int                WEIGHT_W      = 4,
    parameter logic [WEIGHT_W-1:0] WEIGHT_INIT = 4'd8,
    parameter int                POT_W         = 10,
    parameter logic [POT_W-1:0]  THRESHOLD     = 10'd200,
    parameter int                LEAK_SHIFT    = 3,
    parameter int                REFRACT_STEPS = 2,
    parameter logic [23:0]       TICK_DIV      = 24'd10_000_000,
    localparam int               NW            = N_NEURONS * N_INPUTS,
    localparam int               AW            = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [N_INPUTS-1:0]  spikes_in,
    input  logic                 learn,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WEIGHT_W-1:0]  wr_data,
    output logic [WEIGHT_W-1:0]  rd_data,
    output logic [N_NEURONS-1:0] spike_out,
    output logic                 spike_valid,
    output logic                 busy,
    output logic                 overrun
);
    localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int SW = POT_W + ((N_INPUTS > 1) ? $clog2(N_INPUTS) : 1);
    localparam int RW = (REFRACT_STEPS > 0) ? $clog2(REFRACT_STEPS + 1) : 1;
    localparam logic [SW-1:0] POT_MAX = SW'({POT_W{1'b1}});
    localparam logic [23:0] TICK_LAST = TICK_DIV - 24'd1;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
    state_t state, state_nx;

    logic [23:0]          cnt;
    logic                 tick;
    logic [IW-1:0]        idx;
    logic [N_INPUTS-1:0]  snap;
    logic [N_NEURONS-1:0] fired;
    logic [WEIGHT_W-1:0]  w [2**AW];
    logic [POT_W-1:0]     pot [N_NEURONS];
    logic [RW-1:0]        refr [N_NEURONS];
    logic [AW-1:0]        base;
    logic [POT_W-1:0]     p1;
    logic [SW-1:0]        s, s_sat;
    logic                 fire;

    assign tick    = ena && cnt == TICK_LAST;
    assign rd_data = w[wr_addr];

    always_comb begin
        state_nx = state;
        if (state == IDLE && tick)
            state_nx = SWEEP;
        else if (state == SWEEP && idx == IW'(N_NEURONS - 1))
            state_nx = DONE;
        else if (state == DONE)
            state_nx = IDLE;
        busy = state != IDLE;
    end

    // Datapath for the neuron currently selected by idx.
    always_comb begin
        base = AW'(idx * N_INPUTS);
        p1 = (LEAK_SHIFT == 0) ? pot[idx] : pot[idx] - (pot[idx] >> LEAK_SHIFT);
        s = SW'(p1);
        for (int i = 0; i < N_INPUTS; i++)
            s = s + (snap[i] ? SW'(w[base + AW'(i)]) : '0);
        s_sat = (s > POT_MAX) ? POT_MAX : s;
        fire = refr[idx] == '0 && s_sat >= SW'(THRESHOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            snap        <= '0;
            fired       <= '0;
            spike_out   <= '0;
            spike_valid <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                pot[i]  <= '0;
                refr[i] <= '0;
            end
            for (int i = 0; i < 2**AW; i++)
                w[i] <= WEIGHT_INIT;
        end else begin
            if (ena)
                cnt <= tick ? '0 : cnt + 24'd1;
            spike_valid <= state == DONE;
            spike_out   <= (state == DONE) ? fired : '0;
            if (tick && busy)
                overrun <= 1'b1;
            if (state == IDLE && tick) begin
                snap  <= spikes_in;
                idx   <= '0;
                fired <= '0;
            end
            if (state == SWEEP) begin
                idx        <= idx + 1'b1;
                fired[idx] <= fire;
                if (refr[idx] != '0) begin
                    refr[idx] <= refr[idx] - 1'b1;
                    pot[idx]  <= '0;
                end else if (fire) begin
                    refr[idx] <= RW'(REFRACT_STEPS);
                    pot[idx]  <= '0;
                end else begin
                    pot[idx] <= s_sat[POT_W-1:0];
                end
`ifdef LIF_STDP_EN
                if (fire && learn)
                    for (int i = 0; i < N_INPUTS; i++)
                        w[base + AW'(i)] <= snap[i]
                            ? (&w[base + AW'(i)] ? w[base + AW'(i)] : w[base + AW'(i)] + 1'b1)
                            : (|w[base + AW'(i)] ? w[base + AW'(i)] - 1'b1 : w[base + AW'(i)]);
`endif
            end
            if (wr_en && !busy)
                w[wr_addr] <= wr_data;
        end
    end

`ifndef LIF_STDP_EN
    logic unused_learn;
    assign unused_learn = learn;
`endif
endmodule
